mem_port_arbiter: RTL

- Shares the single-port 1K x 20-bit main memory between two requesters.
  - Instruction-fetch port: read-only, driven by the fetch stage.
  - Data port: read/write, driven by the control unit for load/store and stack accesses.
- Per-port req/gnt/rvalid handshake, registered memory-side outputs, configurable memory read latency.
- Data port has priority. An optional starvation guard bounds fetch wait.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory port arbiter.
// The default widths are also used by the control unit and the memory itself.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between the fetch and data ports.
// Data has priority. With MEM_ARB_STARVE_GUARD_EN defined, a saturating
// counter of consecutive fetch losses forces a fetch win once it reaches
// FETCH_MAX_WAIT.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic f_req,
  input  logic d_req,
  output logic owner,
  output logic any_req
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(FETCH_MAX_WAIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_fetch;

  // Pick the winner; a starved fetch overrides data priority
  always_comb begin
    any_req     = f_req | d_req;
    force_fetch = f_req && (starve_cnt == CNT_W'(FETCH_MAX_WAIT));
    owner       = (d_req && !force_fetch) ? OWN_DATA : OWN_FETCH;
  end

  // Count fetch losses at arbitration edges; clear on fetch win or idle fetch
  // NOTE: the async reset is in the sensitivity list so the counter clears
  // without needing a clock edge while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (f_req && owner == OWN_DATA) begin
        if (starve_cnt != CNT_W'(FETCH_MAX_WAIT)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  logic unused_ok;

  // Strict data priority; clock, reset and strobe are not needed here
  always_comb begin
    any_req   = f_req | d_req;
    owner     = d_req ? OWN_DATA : OWN_FETCH;
    unused_ok = ^{clk, rst, arb_en};
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port main memory.
// Fetch port is read-only, data port is read/write and has priority.
// Every output is registered. Optional fetch starvation guard is enabled by
// defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int MEM_LAT        = 1,
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state;
  owner_t     owner_q;
  logic [1:0] lat_cnt;
  logic       sel_owner;
  logic       any_req;

  mem_arb_select #(
    .FETCH_MAX_WAIT(FETCH_MAX_WAIT)
  ) u_select (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == IDLE),
    .f_req  (f_req),
    .d_req  (d_req),
    .owner  (sel_owner),
    .any_req(any_req)
  );

  // Arbitration FSM with all handshake and memory-side outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= OWN_FETCH;
      lat_cnt   <= '0;
      f_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: pulses and memory-side outputs default to 0 each cycle and are
      // overridden below; non-blocking assignment makes the last write win
      // without any read-after-write ordering hazard inside the block.
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            owner_q <= owner_t'(sel_owner);
            if (sel_owner == OWN_DATA) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              f_gnt    <= 1'b1;
              mem_addr <= f_addr;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ISSUE: begin
          lat_cnt <= '0;
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end

        WAIT: begin
          if (lat_cnt == 2'(MEM_LAT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              f_rdata  <= mem_rdata;
              f_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
